// File: rtl/axi_read_master_gen.sv
// AXI4 read-master traffic generator/checker: issues one AR burst per command,
// checks the returned R beats and reports a done pulse with sticky status.
module axi_read_master_gen #(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned ID_W        = 7,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CMP_W       = 128,
  parameter int unsigned RREADY_GAP  = 0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [CMP_W-1:0]  cmd_hdr,
  input  logic              cmd_pat_en,
  input  logic [31:0]       cmd_seed,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              done,
  output logic              pass,
  output logic [5:0]        err_flags,
  output logic [8:0]        beat_cnt,
  output logic [DATA_W-1:0] last_rdata
);

  localparam int unsigned LANES = DATA_W / 32;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned GAP_W = (RREADY_GAP > 1) ? $clog2(RREADY_GAP) : 1;

  // err_flags bit positions
  localparam int unsigned E_DATA  = 0;
  localparam int unsigned E_RESP  = 1;
  localparam int unsigned E_EARLY = 2;
  localparam int unsigned E_MISS  = 3;
  localparam int unsigned E_RID   = 4;
  localparam int unsigned E_TO    = 5;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_GAP, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [CMP_W-1:0]   hdr_q, hdr_d;
  logic               pat_en_q, pat_en_d;
  logic [31:0]        seed_q, seed_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic               cmd_ready_d, arvalid_d, rready_d, done_d, pass_d;
  logic [5:0]         err_d;
  logic [8:0]         beat_cnt_d;
  logic [DATA_W-1:0]  last_rdata_d;
  logic [ID_W-1:0]    arid_d;
  logic [ADDR_W-1:0]  araddr_d;
  logic [7:0]         arlen_d;
  logic [2:0]         arsize_d;
  logic [1:0]         arburst_d;

  logic [31:0]        exp_word;
  logic               lane_mis;
  logic               to_hit;
  logic [TO_W-1:0]    to_inc;
  logic               beat_end;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    pat_en_d     = pat_en_q;
    seed_d       = seed_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cmd_ready_d  = cmd_ready;
    arvalid_d    = arvalid;
    rready_d     = rready;
    done_d       = 1'b0;
    pass_d       = pass;
    err_d        = err_flags;
    beat_cnt_d   = beat_cnt;
    last_rdata_d = last_rdata;
    arid_d       = arid;
    araddr_d     = araddr;
    arlen_d      = arlen;
    arsize_d     = arsize;
    arburst_d    = arburst;
    beat_end     = 1'b0;

    exp_word = seed_q + 32'(beat_cnt);
    lane_mis = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rdata[i*32 +: 32] != exp_word) lane_mis = 1'b1;
    end
    to_hit = (TIMEOUT_CYC != 0) && (to_cnt_q >= TO_W'(TIMEOUT_CYC));
    to_inc = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_AR;
          cmd_ready_d = 1'b0;
          arvalid_d   = 1'b1;
          arid_d      = cmd_id;
          araddr_d    = cmd_addr;
          arlen_d     = cmd_len;
          arsize_d    = cmd_size;
          arburst_d   = cmd_burst;
          hdr_d       = cmd_hdr;
          pat_en_d    = cmd_pat_en;
          seed_d      = cmd_seed;
          err_d       = 6'd0;
          beat_cnt_d  = 9'd0;
          pass_d      = 1'b0;
          to_cnt_d    = '0;
        end
      end
      S_AR: begin
        if (arready) begin
          state_d   = S_RD;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          to_cnt_d  = '0;
        end else if (to_hit) begin
          state_d       = S_FIN;
          arvalid_d     = 1'b0;
          err_d[E_TO]   = 1'b1;
          done_d        = 1'b1;
          pass_d        = 1'b0;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      S_RD: begin
        if (rvalid && rready) begin
          if (beat_cnt == 9'd0) begin
            if (rdata[CMP_W-1:0] != hdr_q) err_d[E_DATA] = 1'b1;
          end else if (pat_en_q && lane_mis) begin
            err_d[E_DATA] = 1'b1;
          end
          if (rresp != 2'b00) err_d[E_RESP] = 1'b1;
          if (rid != arid)    err_d[E_RID]  = 1'b1;
          if (rlast && (beat_cnt < {1'b0, arlen})) err_d[E_EARLY] = 1'b1;
          if (!rlast && (beat_cnt == {1'b0, arlen})) err_d[E_MISS] = 1'b1;
          beat_end     = rlast || (beat_cnt == {1'b0, arlen});
          beat_cnt_d   = beat_cnt + 9'd1;
          last_rdata_d = rdata;
          to_cnt_d     = '0;
          if (beat_end) begin
            state_d  = S_FIN;
            rready_d = 1'b0;
            done_d   = 1'b1;
            pass_d   = ~|err_d;
          end else if (RREADY_GAP > 0) begin
            state_d   = S_GAP;
            rready_d  = 1'b0;
            gap_cnt_d = GAP_W'(RREADY_GAP - 1);
          end
        end else if (to_hit) begin
          state_d     = S_FIN;
          rready_d    = 1'b0;
          err_d[E_TO] = 1'b1;
          done_d      = 1'b1;
          pass_d      = 1'b0;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      S_GAP: begin
        to_cnt_d = to_inc;
        if (gap_cnt_q == '0) begin
          state_d  = S_RD;
          rready_d = 1'b1;
          to_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_FIN: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      hdr_q      <= '0;
      pat_en_q   <= 1'b0;
      seed_q     <= 32'd0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      cmd_ready  <= 1'b1;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_flags  <= 6'd0;
      beat_cnt   <= 9'd0;
      last_rdata <= '0;
      arid       <= '0;
      araddr     <= '0;
      arlen      <= 8'd0;
      arsize     <= 3'd0;
      arburst    <= 2'd0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      pat_en_q   <= pat_en_d;
      seed_q     <= seed_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      cmd_ready  <= cmd_ready_d;
      arvalid    <= arvalid_d;
      rready     <= rready_d;
      done       <= done_d;
      pass       <= pass_d;
      err_flags  <= err_d;
      beat_cnt   <= beat_cnt_d;
      last_rdata <= last_rdata_d;
      arid       <= arid_d;
      araddr     <= araddr_d;
      arlen      <= arlen_d;
      arsize     <= arsize_d;
      arburst    <= arburst_d;
    end
  end

endmodule
